// File: rtl/dlk_pcm_pkg.sv
// rtl/dlk_pcm_pkg.sv - shared defaults and slot constants for the AGC downlink PCM receiver
// Purpose: default frame geometry plus the slot numbers that frame a downlink word.
// Ports: none (package).
package dlk_pcm_pkg;

   localparam int DEF_SLOT_CLKS   = 21;
   localparam int DEF_PULSE_CLKS  = 4;
   localparam int DEF_NBITS       = 40;
   localparam int DEF_FRAME_SLOTS = 1024;

   localparam int SLOT_START = 0;
   localparam int SLOT_END   = DEF_NBITS + 1;

   // Slot that carries DKEND for a word of nbits bits.
   function automatic int slot_end(input int nbits);
      return nbits + 1;
   endfunction

endpackage

// File: rtl/dlk_pcm_timer.sv
// rtl/dlk_pcm_timer.sv - CLK edge detect, slot/phase counters and downlink strobe decode
// Purpose: turns the AGC bit clock into per-slot strobes and tells the receiver when to sample.
// Ports:
//   SIM_CLK, SIM_RST  simulation clock, synchronous active-high reset
//   CLK               AGC bit clock, sampled in the SIM_CLK domain
//   tick_o            one SIM_CLK pulse per CLK rising edge
//   sample_en_o       current phase is the one whose tick clears the strobe (qualify with tick_o)
//   slot_o            current slot within the frame
//   dkstrt_o, dkbsnc_o, dkend_o  registered downlink strobes
module dlk_pcm_timer
   import dlk_pcm_pkg::*;
#(
   parameter int SLOT_CLKS   = DEF_SLOT_CLKS,
   parameter int PULSE_CLKS  = DEF_PULSE_CLKS,
   parameter int NBITS       = DEF_NBITS,
   parameter int FRAME_SLOTS = DEF_FRAME_SLOTS
) (
   input  logic                           SIM_CLK,
   input  logic                           SIM_RST,
   input  logic                           CLK,
   output logic                           tick_o,
   output logic                           sample_en_o,
   output logic [$clog2(FRAME_SLOTS)-1:0] slot_o,
   output logic                           dkstrt_o,
   output logic                           dkbsnc_o,
   output logic                           dkend_o
);

   localparam int PW = $clog2(SLOT_CLKS);
   localparam int SW = $clog2(FRAME_SLOTS);

   logic          clk_q;
   logic [PW-1:0] phase_q, phase_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          dkstrt_q, dkbsnc_q, dkend_q;
   logic          tick, wrap;

   assign tick = CLK & ~clk_q;
   // The tick that wraps the phase opens a new slot and raises its strobe.
   assign wrap = tick && (phase_q == PW'(SLOT_CLKS - 1));

   always_comb begin
      phase_d = phase_q;
      slot_d  = slot_q;
      if (tick) begin
         phase_d = (phase_q == PW'(SLOT_CLKS - 1)) ? '0 : phase_q + PW'(1);
      end
      if (wrap) begin
         slot_d = (slot_q == SW'(FRAME_SLOTS - 1)) ? '0 : slot_q + SW'(1);
      end
   end

   // Phase/slot reset one slot before the wrap so the first DKSTRT
   // appears on the second CLK rise after reset.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         clk_q    <= 1'b0;
         phase_q  <= PW'(SLOT_CLKS - 2);
         slot_q   <= SW'(FRAME_SLOTS - 1);
         dkstrt_q <= 1'b0;
         dkbsnc_q <= 1'b0;
         dkend_q  <= 1'b0;
      end else begin
         clk_q   <= CLK;
         phase_q <= phase_d;
         slot_q  <= slot_d;
         if (wrap) begin
            dkstrt_q <= (slot_d == SW'(SLOT_START));
            dkbsnc_q <= (slot_d >= SW'(1)) && (slot_d <= SW'(NBITS));
            dkend_q  <= (slot_d == SW'(slot_end(NBITS)));
         end else if (tick && (phase_q == PW'(PULSE_CLKS - 1))) begin
            dkstrt_q <= 1'b0;
            dkbsnc_q <= 1'b0;
            dkend_q  <= 1'b0;
         end
      end
   end

   assign tick_o      = tick;
   assign sample_en_o = (phase_q == PW'(PULSE_CLKS - 1));
   assign slot_o      = slot_q;
   assign dkstrt_o    = dkstrt_q;
   assign dkbsnc_o    = dkbsnc_q;
   assign dkend_o     = dkend_q;

endmodule

// File: rtl/dlk_pcm_receiver.sv
// rtl/dlk_pcm_receiver.sv - AGC digital downlink ground-station receiver with word handshake
// Purpose: drives DKSTRT/DKBSNC/DKEND, shifts DKDATA into NBITS-bit words and hands them out.
// Ports:
//   SIM_CLK, SIM_RST        simulation clock, synchronous active-high reset
//   CLK, DKDATA             AGC bit clock and serial downlink data
//   DKSTRT, DKBSNC, DKEND   strobes back to the AGC
//   word_data, word_valid   last captured word (first bit in MSB) and its valid flag
//   word_ack                consumer accepts word_data
//   overrun                 sticky: a word completed while the previous one was unaccepted
//   word_count              completed words, wraps at 16 bits
module dlk_pcm_receiver
   import dlk_pcm_pkg::*;
#(
   parameter int SLOT_CLKS   = DEF_SLOT_CLKS,
   parameter int PULSE_CLKS  = DEF_PULSE_CLKS,
   parameter int NBITS       = DEF_NBITS,
   parameter int FRAME_SLOTS = DEF_FRAME_SLOTS
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             CLK,
   input  logic             DKDATA,
   output logic             DKSTRT,
   output logic             DKBSNC,
   output logic             DKEND,
   output logic [NBITS-1:0] word_data,
   output logic             word_valid,
   input  logic             word_ack,
   output logic             overrun,
   output logic [15:0]      word_count
);

   localparam int SW = $clog2(FRAME_SLOTS);
   localparam int BW = $clog2(NBITS + 1);

   logic             tick, clear_phase, sample, complete;
   logic [SW-1:0]    slot;
   logic [NBITS-1:0] shreg_q, shreg_d, word_data_q, word_data_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             word_valid_q, word_valid_d;
   logic             overrun_q, overrun_d;
   logic [15:0]      word_count_q, word_count_d;

   dlk_pcm_timer #(
      .SLOT_CLKS  (SLOT_CLKS),
      .PULSE_CLKS (PULSE_CLKS),
      .NBITS      (NBITS),
      .FRAME_SLOTS(FRAME_SLOTS)
   ) u_timer (
      .SIM_CLK    (SIM_CLK),
      .SIM_RST    (SIM_RST),
      .CLK        (CLK),
      .tick_o     (tick),
      .sample_en_o(clear_phase),
      .slot_o     (slot),
      .dkstrt_o   (DKSTRT),
      .dkbsnc_o   (DKBSNC),
      .dkend_o    (DKEND)
   );

   // DKDATA is taken on the tick that drops the strobe, giving the AGC the
   // whole pulse to settle the bit.
   assign sample   = tick & clear_phase;
   // A word is only delivered if this frame saw its DKSTRT and every DKBSNC.
   assign complete = sample && (slot == SW'(slot_end(NBITS))) && (bitcnt_q == BW'(NBITS));

   always_comb begin
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      overrun_d    = overrun_q;
      word_count_d = word_count_q;
      if (sample) begin
         if (slot == SW'(SLOT_START)) begin
            shreg_d  = '0;
            bitcnt_d = '0;
         end else if (slot <= SW'(NBITS)) begin
            shreg_d  = {shreg_q[NBITS-2:0], DKDATA};
            bitcnt_d = bitcnt_q + BW'(1);
         end
      end
      if (complete) begin
         word_data_d  = shreg_q;
         word_valid_d = 1'b1;
         word_count_d = word_count_q + 16'd1;
         // An ack landing on the completion cycle consumes the old word.
         if (word_valid_q && !word_ack) begin
            overrun_d = 1'b1;
         end
      end else if (word_valid_q && word_ack) begin
         word_valid_d = 1'b0;
      end
   end

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         word_count_q <= '0;
      end else begin
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         overrun_q    <= overrun_d;
         word_count_q <= word_count_d;
      end
   end

   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;
   assign overrun    = overrun_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_dlk_pcm_receiver.sv
// tb/tb_dlk_pcm_receiver.sv - self-checking bench for dlk_pcm_receiver
module tb_dlk_pcm_receiver;

   localparam int SLOT  = 21;
   localparam int PULSE = 4;
   localparam int NB    = 40;
   localparam int FRAME = 48;

   logic          SIM_CLK = 1'b0;
   logic          SIM_RST;
   logic          CLK;
   logic          DKDATA;
   logic          DKSTRT, DKBSNC, DKEND;
   logic [NB-1:0] word_data;
   logic          word_valid;
   logic          word_ack;
   logic          overrun;
   logic [15:0]   word_count;

   int total = 0;
   int bad   = 0;
   int ticks = 0;
   int exp_count = 0;
   logic [NB-1:0] words [16];

   always #5 SIM_CLK = ~SIM_CLK;

   dlk_pcm_receiver #(
      .SLOT_CLKS  (SLOT),
      .PULSE_CLKS (PULSE),
      .NBITS      (NB),
      .FRAME_SLOTS(FRAME)
   ) dut (
      .SIM_CLK   (SIM_CLK),
      .SIM_RST   (SIM_RST),
      .CLK       (CLK),
      .DKDATA    (DKDATA),
      .DKSTRT    (DKSTRT),
      .DKBSNC    (DKBSNC),
      .DKEND     (DKEND),
      .word_data (word_data),
      .word_valid(word_valid),
      .word_ack  (word_ack),
      .overrun   (overrun),
      .word_count(word_count)
   );

   // Reference timeline: tick n (1-based since reset) is offset m=n-2 into the
   // strobe schedule; each slot is SLOT ticks, strobe high for the first PULSE.
   function automatic logic [2:0] exp_strobes(input int n);
      int m, s;
      if (n < 2) return 3'b000;
      m = n - 2;
      if ((m % SLOT) >= PULSE) return 3'b000;
      s = (m / SLOT) % FRAME;
      if (s == 0) return 3'b100;
      if (s <= NB) return 3'b010;
      if (s == NB + 1) return 3'b001;
      return 3'b000;
   endfunction

   function automatic bit is_end(input int n);
      int m;
      if (n < 2) return 1'b0;
      m = n - 2;
      return ((m % SLOT) == PULSE) && (((m / SLOT) % FRAME) == NB + 1);
   endfunction

   function automatic int frame_of(input int n);
      return ((n - 2) / SLOT) / FRAME;
   endfunction

   function automatic int slot_of(input int n);
      return ((n - 2) / SLOT) % FRAME;
   endfunction

   task automatic fill_words();
      logic [63:0] r;
      for (int i = 0; i < 16; i++) begin
         r = {$urandom(), $urandom()};
         words[i] = r[NB-1:0];
      end
   endtask

   // One CLK period (two SIM_CLK cycles); ack, if any, is a single SIM_CLK
   // pulse on the tick edge. Returns at a negedge for sampling.
   task automatic clk_period(input logic ack);
      int n, m, s;
      n = ticks + 1;
      m = n - 2;
      DKDATA = ($urandom_range(0, 1) != 0);
      if (m >= 0) begin
         s = (m / SLOT) % FRAME;
         if (s >= 1 && s <= NB) DKDATA = words[((m / SLOT) / FRAME) % 16][NB - s];
      end
      word_ack = ack;
      CLK = 1'b1;
      @(negedge SIM_CLK);
      ticks = n;
      word_ack = 1'b0;
      CLK = 1'b0;
      @(negedge SIM_CLK);
   endtask

   task automatic run_to_end(input logic ack_at_end, output int valid_hits);
      int guard;
      valid_hits = 0;
      guard = 0;
      while (!is_end(ticks + 1) && guard < 5000) begin
         clk_period(1'b0);
         if (word_valid) valid_hits++;
         guard++;
      end
      clk_period(ack_at_end);
   endtask

   task automatic test_reset();
      CLK = 1'b0;
      word_ack = 1'b0;
      DKDATA = 1'b0;
      SIM_RST = 1'b1;
      repeat (3) @(negedge SIM_CLK);
      SIM_RST = 1'b0;
      ticks = 0;
      exp_count = 0;
      total++;
      if ({DKSTRT, DKBSNC, DKEND} !== 3'b000) begin
         bad++; $display("FAIL reset_strobes got=%b exp=000", {DKSTRT, DKBSNC, DKEND});
      end
      total++;
      if (word_data !== '0) begin
         bad++; $display("FAIL reset_word_data got=%h exp=0", word_data);
      end
      total++;
      if (word_valid !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL reset_flags got valid=%b overrun=%b exp=0/0", word_valid, overrun);
      end
      total++;
      if (word_count !== 16'd0) begin
         bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count);
      end
   endtask

   task automatic test_strobes();
      logic [2:0] got, exp;
      int first_strt, strt_len, bsnc_pulses, end_pulses, overlap, early, mism, guard;
      logic prev_b, prev_e;
      first_strt = -1; strt_len = 0; bsnc_pulses = 0; end_pulses = 0;
      overlap = 0; early = 0; mism = 0; guard = 0;
      prev_b = 1'b0; prev_e = 1'b0;
      words[0] = 40'hA5_C3F0_0F5A;
      do begin
         clk_period(1'b0);
         got = {DKSTRT, DKBSNC, DKEND};
         exp = exp_strobes(ticks);
         total++;
         if (got !== exp) begin
            bad++;
            if (mism < 8) $display("FAIL strobe_tick%0d got=%b exp=%b", ticks, got, exp);
            mism++;
         end
         if (DKSTRT === 1'b1 && first_strt < 0) first_strt = ticks;
         if (DKSTRT === 1'b1) strt_len++;
         if (DKBSNC === 1'b1 && !prev_b) bsnc_pulses++;
         if (DKEND === 1'b1 && !prev_e) end_pulses++;
         if ((int'(DKSTRT) + int'(DKBSNC) + int'(DKEND)) > 1) overlap++;
         if (!is_end(ticks) && word_valid !== 1'b0) early++;
         prev_b = DKBSNC;
         prev_e = DKEND;
         guard++;
      end while (!is_end(ticks) && guard < 5000);
      exp_count++;
      total++;
      if (first_strt != 2 || strt_len != PULSE) begin
         bad++; $display("FAIL dkstrt_timing got first=%0d len=%0d exp first=2 len=%0d", first_strt, strt_len, PULSE);
      end
      total++;
      if (bsnc_pulses != NB || end_pulses != 1) begin
         bad++; $display("FAIL pulse_counts got bsnc=%0d end=%0d exp bsnc=%0d end=1", bsnc_pulses, end_pulses, NB);
      end
      total++;
      if (overlap != 0 || early != 0) begin
         bad++; $display("FAIL exclusive_or_early got overlap=%0d early_valid=%0d exp 0/0", overlap, early);
      end
      total++;
      if (word_data !== 40'hA5C3F00F5A || word_valid !== 1'b1) begin
         bad++; $display("FAIL first_word got=%h valid=%b exp=a5c3f00f5a valid=1", word_data, word_valid);
      end
      total++;
      if (word_count !== 16'(exp_count)) begin
         bad++; $display("FAIL first_count got=%0d exp=%0d", word_count, exp_count);
      end
   endtask

   task automatic test_ack_immediate();
      int hits, f;
      for (int k = 0; k < 3; k++) begin
         clk_period(1'b1);
         total++;
         if (word_valid !== 1'b0) begin
            bad++; $display("FAIL ack_clears_valid%0d got=%b exp=0", k, word_valid);
         end
         run_to_end(1'b0, hits);
         exp_count++;
         f = frame_of(ticks);
         total++;
         if (hits != 0) begin
            bad++; $display("FAIL valid_between%0d got=%0d exp=0", k, hits);
         end
         total++;
         if (word_valid !== 1'b1 || word_data !== words[f % 16]) begin
            bad++; $display("FAIL ack_word%0d got=%h valid=%b exp=%h valid=1", k, word_data, word_valid, words[f % 16]);
         end
      end
      total++;
      if (word_count !== 16'(exp_count) || overrun !== 1'b0) begin
         bad++; $display("FAIL ack_totals got count=%0d overrun=%b exp count=%0d overrun=0", word_count, overrun, exp_count);
      end
   endtask

   task automatic test_ack_same_cycle();
      int hits, f;
      clk_period(1'b1);
      run_to_end(1'b0, hits);
      exp_count++;
      run_to_end(1'b1, hits);
      exp_count++;
      f = frame_of(ticks);
      total++;
      if (word_valid !== 1'b1 || word_data !== words[f % 16]) begin
         bad++; $display("FAIL same_cycle_word got=%h valid=%b exp=%h valid=1", word_data, word_valid, words[f % 16]);
      end
      total++;
      if (overrun !== 1'b0 || word_count !== 16'(exp_count)) begin
         bad++; $display("FAIL same_cycle_flags got overrun=%b count=%0d exp overrun=0 count=%0d", overrun, word_count, exp_count);
      end
      clk_period(1'b1);
   endtask

   task automatic test_static_clk();
      int hits, f, guard;
      guard = 0;
      while (!(ticks >= 2 && ((ticks - 2) % SLOT) == PULSE - 1 && slot_of(ticks) == 10) && guard < 5000) begin
         clk_period(1'b0);
         guard++;
      end
      CLK = 1'b0;
      repeat (40) @(negedge SIM_CLK);
      total++;
      if ({DKSTRT, DKBSNC, DKEND} !== exp_strobes(ticks)) begin
         bad++; $display("FAIL static_low_strobes got=%b exp=%b", {DKSTRT, DKBSNC, DKEND}, exp_strobes(ticks));
      end
      // DKDATA still holds bit 10 of this frame; CLK held high yields one tick.
      CLK = 1'b1;
      repeat (30) @(negedge SIM_CLK);
      ticks++;
      CLK = 1'b0;
      @(negedge SIM_CLK);
      total++;
      if ({DKSTRT, DKBSNC, DKEND} !== exp_strobes(ticks)) begin
         bad++; $display("FAIL static_high_strobes got=%b exp=%b", {DKSTRT, DKBSNC, DKEND}, exp_strobes(ticks));
      end
      run_to_end(1'b0, hits);
      exp_count++;
      f = frame_of(ticks);
      total++;
      if (word_valid !== 1'b1 || word_data !== words[f % 16]) begin
         bad++; $display("FAIL static_word got=%h valid=%b exp=%h valid=1", word_data, word_valid, words[f % 16]);
      end
   endtask

   task automatic test_overrun();
      int hits, f;
      clk_period(1'b1);
      run_to_end(1'b0, hits);
      exp_count++;
      total++;
      if (word_valid !== 1'b1 || overrun !== 1'b0) begin
         bad++; $display("FAIL overrun_first got valid=%b overrun=%b exp 1/0", word_valid, overrun);
      end
      run_to_end(1'b0, hits);
      exp_count++;
      f = frame_of(ticks);
      total++;
      if (overrun !== 1'b1 || word_data !== words[f % 16]) begin
         bad++; $display("FAIL overrun_second got overrun=%b data=%h exp overrun=1 data=%h", overrun, word_data, words[f % 16]);
      end
      total++;
      if (word_count !== 16'(exp_count)) begin
         bad++; $display("FAIL overrun_count got=%0d exp=%0d", word_count, exp_count);
      end
      clk_period(1'b1);
      total++;
      if (overrun !== 1'b1 || word_valid !== 1'b0) begin
         bad++; $display("FAIL overrun_sticky got overrun=%b valid=%b exp 1/0", overrun, word_valid);
      end
   endtask

   task automatic test_reset_mid();
      int hits, guard;
      guard = 0;
      while (!(ticks >= 2 && ((ticks - 2) % SLOT) == 2 && slot_of(ticks) == 20) && guard < 5000) begin
         clk_period(1'b0);
         guard++;
      end
      fill_words();
      test_reset();
      clk_period(1'b0);
      total++;
      if (DKSTRT !== 1'b0) begin
         bad++; $display("FAIL post_reset_tick1 got=%b exp=0", DKSTRT);
      end
      clk_period(1'b0);
      total++;
      if (DKSTRT !== 1'b1) begin
         bad++; $display("FAIL post_reset_tick2 got=%b exp=1", DKSTRT);
      end
      run_to_end(1'b0, hits);
      exp_count++;
      total++;
      if (word_data !== words[0] || word_valid !== 1'b1 || overrun !== 1'b0) begin
         bad++; $display("FAIL post_reset_word got=%h valid=%b overrun=%b exp=%h 1 0", word_data, word_valid, overrun, words[0]);
      end
      total++;
      if (word_count !== 16'(exp_count)) begin
         bad++; $display("FAIL post_reset_count got=%0d exp=%0d", word_count, exp_count);
      end
   endtask

   initial begin
      SIM_RST = 1'b1;
      CLK = 1'b0;
      DKDATA = 1'b0;
      word_ack = 1'b0;
      fill_words();
      test_reset();
      test_strobes();
      test_ack_immediate();
      test_ack_same_cycle();
      test_static_clk();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dlk_pcm_receiver.md
Name: dlk_pcm_receiver

Overview:
- Bench-side ground-station model of the AGC digital downlink.
- Derives the downlink strobes DKSTRT, DKBSNC and DKEND from the AGC CLK output and samples DKDATA serially into 40-bit words.
- Presents each completed word to a consumer through a valid/ack handshake.
- Replaces the ad-hoc PCM counter logic in top-level benches; sits between the `agc` instance and bench checkers/loggers.

Parameters:
- SLOT_CLKS, 21: CLK rising edges per PCM slot.
- PULSE_CLKS, 4: CLK rising edges each strobe stays high; must be < SLOT_CLKS.
- NBITS, 40: bit slots per downlink word, i.e. DKBSNC strobes between DKSTRT and DKEND.
- FRAME_SLOTS, 1024: slots per frame; must be >= NBITS+2.

Ports:
- SIM_CLK  input  1  simulation clock; all state on rising edge.
- SIM_RST  input  1  synchronous active-high reset.
- CLK  input  1  AGC bit clock output; sampled in SIM_CLK domain.
- DKDATA  input  1  AGC serial downlink data.
- DKSTRT  output  1  word start strobe to AGC.
- DKBSNC  output  1  bit sync strobe to AGC.
- DKEND  output  1  word end strobe to AGC.
- word_data  output  NBITS  last captured word; bit NBITS-1 = first bit received.
- word_valid  output  1  word_data holds an unacknowledged word.
- word_ack  input  1  consumer accepts word_data.
- overrun  output  1  sticky: a word completed while word_valid was still high.
- word_count  output  16  completed words, wraps 0xFFFF->0.

Behaviour:
- Edge detect: clk_q <= CLK. tick = CLK & ~clk_q. All counters advance only on tick.
- phase counter, reset SLOT_CLKS-2: on tick, phase <= (phase==SLOT_CLKS-1) ? 0 : phase+1.
- slot counter, reset FRAME_SLOTS-1: on tick with phase==0, slot <= (slot==FRAME_SLOTS-1) ? 0 : slot+1, and strobe <= 1.
- On tick with phase==PULSE_CLKS: strobe <= 0.
- First strobe (slot 0) begins 2 ticks after reset release.
- Strobe decode, registered together with strobe:
  - DKSTRT = strobe & slot==0.
  - DKBSNC = strobe & 1<=slot<=NBITS.
  - DKEND = strobe & slot==NBITS+1.
  - Slots NBITS+2 .. FRAME_SLOTS-1 are idle; all strobes stay 0.
- Sampling: on the tick that clears strobe (phase==PULSE_CLKS):
  - If slot in 1..NBITS: shreg <= {shreg[NBITS-2:0], DKDATA}.
  - If slot==0: shreg <= 0 and bitcnt <= 0. Each DKBSNC sample increments bitcnt.
- Completion: on the tick clearing DKEND, if bitcnt==NBITS:
  - word_data <= shreg; word_valid <= 1; word_count increments.
  - If word_valid was already 1 and word_ack is not high that cycle: overrun <= 1, and word_data is overwritten with the new word.
- If bitcnt != NBITS at DKEND: no word is produced. This only occurs for a frame already in progress at reset.
- Handshake:
  - word_ack while word_valid clears word_valid next SIM_CLK.
  - Completion and ack in the same cycle: word_valid stays 1 with the new data, no overrun.
  - word_ack while not valid: ignored.
- overrun clears only on SIM_RST.
- Reset values: DKSTRT/DKBSNC/DKEND=0, word_data=0, word_valid=0, overrun=0, word_count=0, shreg=0, bitcnt=0, clk_q=0. A partial word in flight at reset is discarded.
- CLK static: no ticks, all state holds, strobes frozen in their current level.
- Latency: word_valid rises 1 SIM_CLK after the tick that ends DKEND.

Decomposition:
- Shared package dlk_pcm_pkg: default SLOT_CLKS/PULSE_CLKS/NBITS/FRAME_SLOTS, and localparams SLOT_START=0, SLOT_END=NBITS+1.
- One natural sub-module: dlk_pcm_timer. It holds the CLK edge detect, phase/slot counters and strobe decode, and outputs tick, sample_en and slot.
- The top level holds shreg, bitcnt, the handshake and the counters.

Test Plan:
- Reset release, free-running CLK, DKDATA=0 -> DKSTRT high for exactly 4 CLK periods starting at the 2nd CLK rise. Then 40 DKBSNC pulses spaced 21 CLK periods, then one DKEND. Strobes are mutually exclusive.
- DKDATA driven per bit from pattern 40'hA5_C3F0_0F5A, first bit = MSB -> word_data=40'hA5C3F00F5A, word_valid=1, word_count=1.
- Consumer acks immediately for 3 frames -> word_count=3, overrun=0, word_valid low between words.
- Never ack across 2 frames -> overrun=1 after the 2nd DKEND; word_data equals the 2nd word; word_count=2.
- Ack asserted on the exact completion cycle -> word_valid stays 1 with the new data, overrun stays 0.
- SIM_RST pulsed during bit slot 20, then released -> all outputs 0. Next DKSTRT follows 2 CLK rises later, and the next full word is captured correctly.
